// File: rtl/key_buffer_pkg.sv
// Defaults and types shared between key_loader and key_buffer.
package key_buffer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 54;
  localparam int unsigned DEFAULT_ADDR_WIDTH    = 11;
  localparam int unsigned DEFAULT_DP            = 256;
  localparam int unsigned DEFAULT_LANES         = 8;
  localparam int unsigned DEFAULT_NUM_LIMBS     = 6;
  localparam int unsigned DEFAULT_ROWS_PER_LIMB = 256;

  localparam int unsigned DEFAULT_BEATS = DEFAULT_DP / DEFAULT_LANES;
  localparam int unsigned DEFAULT_TOTAL = DEFAULT_NUM_LIMBS * DEFAULT_ROWS_PER_LIMB;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} loader_state_e;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_row_assembler.sv
// Packs LANES-wide input beats into a full dp-bank row; the completing beat is merged
// combinationally so the row is available in the same cycle as its last handshake.
module key_row_assembler
  import key_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned dp         = DEFAULT_DP,
  parameter int unsigned LANES      = DEFAULT_LANES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_fire,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        row_complete,
  output logic [dp*DATA_WIDTH-1:0]    row_data
);

  localparam int unsigned BEATS = dp / LANES;
  localparam int unsigned BW    = LANES * DATA_WIDTH;
  localparam int unsigned CW    = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [CW-1:0]            beat_cnt_q;
  logic [dp*DATA_WIDTH-1:0] asm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      asm_q      <= '0;
    end else if (clear) begin
      beat_cnt_q <= '0;
    end else if (in_fire) begin
      asm_q[32'(beat_cnt_q) * BW +: BW] <= in_data;
      beat_cnt_q <= (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
    end
  end

  assign row_complete = in_fire && (beat_cnt_q == LAST_BEAT);

  always_comb begin
    row_data = asm_q;
    if (in_fire) row_data[32'(beat_cnt_q) * BW +: BW] = in_data;
  end

endmodule

// File: rtl/key_loader.sv
// Streams key limbs from memory beats into key_buffer as broadcast-address row writes.
module key_loader
  import key_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int unsigned dp            = DEFAULT_DP,
  parameter int unsigned LANES         = DEFAULT_LANES,
  parameter int unsigned NUM_LIMBS     = DEFAULT_NUM_LIMBS,
  parameter int unsigned ROWS_PER_LIMB = DEFAULT_ROWS_PER_LIMB
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic [dp*ADDR_WIDTH-1:0]    buf_addr_write,
  output logic [dp*DATA_WIDTH-1:0]    buf_data_in,
  output logic                        buf_we
);

  localparam int unsigned TOTAL = NUM_LIMBS * ROWS_PER_LIMB;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(TOTAL - 1);

  loader_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [ADDR_WIDTH-1:0]    row_cnt_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [dp*DATA_WIDTH-1:0] data_q;
  logic                     we_q;

  logic                     start_accept;
  logic                     in_fire;
  logic                     row_complete;
  logic [dp*DATA_WIDTH-1:0] row_data;

  assign start_accept = (state_q == IDLE) && start;
  assign in_fire      = (state_q == FILL) && in_valid;

  key_row_assembler #(
    .DATA_WIDTH(DATA_WIDTH),
    .dp        (dp),
    .LANES     (LANES)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_accept),
    .in_fire     (in_fire),
    .in_data     (in_data),
    .row_complete(row_complete),
    .row_data    (row_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL:  if (row_complete && (row_cnt_q == LAST_ROW)) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      row_cnt_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= row_complete;
      if (start_accept) begin
        base_q    <= base_addr;
        row_cnt_q <= '0;
      end
      // Separate output register lets the next row assemble while this one is written.
      if (row_complete) begin
        addr_q    <= base_q + row_cnt_q;
        data_q    <= row_data;
        row_cnt_q <= row_cnt_q + 1'b1;
      end
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign in_ready       = (state_q == FILL);
  assign buf_we         = we_q;
  assign buf_addr_write = {dp{addr_q}};
  assign buf_data_in    = data_q;

endmodule

// File: tb/tb_key_loader.sv
// Scoreboard bench for key_loader at reduced size (16 banks, 4 lanes, 8 rows per load).
module tb_key_loader;

  localparam int DW     = 54;
  localparam int AW     = 4;
  localparam int DP     = 16;
  localparam int LN     = 4;
  localparam int NL     = 2;
  localparam int RPL    = 4;
  localparam int BEATS  = DP / LN;
  localparam int TOTAL  = NL * RPL;
  localparam int NBEATS = TOTAL * BEATS;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic            busy, done, in_valid, in_ready, buf_we;
  logic [LN*DW-1:0] in_data;
  logic [DP*AW-1:0] buf_addr_write;
  logic [DP*DW-1:0] buf_data_in;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int we_cnt = 0;
  logic prev_we = 1'b0;

  logic [AW-1:0]    exp_addr_q[$];
  logic [DP*DW-1:0] exp_data_q[$];

  key_loader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .dp           (DP),
    .LANES        (LN),
    .NUM_LIMBS    (NL),
    .ROWS_PER_LIMB(RPL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .buf_addr_write(buf_addr_write),
    .buf_data_in   (buf_data_in),
    .buf_we        (buf_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LN*DW-1:0] beat_data(input int b);
    logic [LN*DW-1:0] v;
    for (int l = 0; l < LN; l++) v[l*DW +: DW] = DW'(16 * (b / BEATS) + (b % BEATS) * LN + l);
    return v;
  endfunction

  function automatic logic [DP*DW-1:0] row_model(input int r);
    logic [DP*DW-1:0] v;
    for (int k = 0; k < DP; k++) v[k*DW +: DW] = DW'(16 * r + k);
    return v;
  endfunction

  // Scoreboard monitor: every write strobe pops one expected row.
  initial begin
    logic [AW-1:0]    ea;
    logic [DP*DW-1:0] ed;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        if (buf_we) begin
          we_cnt++;
          tests++;
          if (prev_we) begin
            fails++;
            $display("FAIL we_back_to_back: buf_we high two cycles running at cycle %0d", cyc);
          end
          tests++;
          if (exp_addr_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_we: write to %0h with empty scoreboard", buf_addr_write[AW-1:0]);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            for (int k = 0; k < DP; k++) begin
              if (buf_addr_write[k*AW +: AW] !== ea) begin
                fails++;
                $display("FAIL row_addr bank %0d: got %0h expected %0h", k,
                         buf_addr_write[k*AW +: AW], ea);
                break;
              end
            end
            tests++;
            for (int k = 0; k < DP; k++) begin
              if (buf_data_in[k*DW +: DW] !== ed[k*DW +: DW]) begin
                fails++;
                $display("FAIL row_data addr %0h bank %0d: got %0h expected %0h", ea, k,
                         buf_data_in[k*DW +: DW], ed[k*DW +: DW]);
                break;
              end
            end
          end
        end
        prev_we = buf_we;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives one whole load; rows are pushed to the scoreboard as their last beat is driven.
  task automatic run_load(input logic [AW-1:0] b, input bit stall, input int inj_beat,
                          output int c_start, output int c_last, output int c_done,
                          output int c_idle);
    int  beat;
    bit  v;
    beat = 0;
    c_last = -1;
    c_done = -1;
    c_idle = -1;
    tick();
    start = 1'b1;
    base_addr = b;
    c_start = cyc;
    for (int bound = 0; bound < 400 && c_idle < 0; bound++) begin
      tick();
      start = 1'b0;
      if (done && c_done < 0) c_done = cyc;
      if (!busy) begin
        c_idle = cyc;
      end else if (beat < NBEATS) begin
        if (beat == inj_beat) begin
          start = 1'b1;
          base_addr = 4'd9;
        end
        v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid = v;
        in_data = beat_data(beat);
        if (v && in_ready) begin
          if (beat % BEATS == BEATS - 1) begin
            exp_addr_q.push_back(AW'(b + AW'(beat / BEATS)));
            exp_data_q.push_back(row_model(beat / BEATS));
          end
          if (beat == NBEATS - 1) c_last = cyc;
          beat++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (c_idle < 0) begin
      tests++;
      fails++;
      $display("FAIL load_timeout: busy still %0b after 400 cycles, %0d beats sent", busy, beat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    base_addr = '0;
    in_data = '0;
    repeat (3) tick();
    tests++;
    if ({busy, done, in_ready, buf_we} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: busy/done/in_ready/we got %b expected 0000",
               {busy, done, in_ready, buf_we});
    end
    tests++;
    if (buf_addr_write !== '0 || buf_data_in !== '0) begin
      fails++;
      $display("FAIL reset_bus: addr %0h data nonzero=%0b expected 0", buf_addr_write,
               |buf_data_in);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cs, cl, cd, ci, w0;
    w0 = we_cnt;
    run_load(4'd0, 1'b0, -1, cs, cl, cd, ci);
    tests++;
    if (we_cnt - w0 != TOTAL) begin
      fails++;
      $display("FAIL basic_we_count: got %0d expected %0d", we_cnt - w0, TOTAL);
    end
    tests++;
    if (cd - cl != 2) begin
      fails++;
      $display("FAIL basic_done_latency: got %0d expected 2", cd - cl);
    end
    tests++;
    if (ci - cs != NBEATS + 3) begin
      fails++;
      $display("FAIL basic_duration: got %0d expected %0d", ci - cs, NBEATS + 3);
    end
    tests++;
    if (exp_addr_q.size() != 0) begin
      fails++;
      $display("FAIL basic_leftover: got %0d rows unwritten expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_wrap();
    int cs, cl, cd, ci, w0;
    w0 = we_cnt;
    run_load(4'd12, 1'b0, -1, cs, cl, cd, ci);
    tests++;
    if (we_cnt - w0 != TOTAL || exp_addr_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_writes: got %0d writes, %0d left expected %0d, 0", we_cnt - w0,
               exp_addr_q.size(), TOTAL);
    end
  endtask

  task automatic test_stalls();
    int cs, cl, cd, ci, w0;
    w0 = we_cnt;
    run_load(4'd0, 1'b1, -1, cs, cl, cd, ci);
    tests++;
    if (we_cnt - w0 != TOTAL || exp_addr_q.size() != 0) begin
      fails++;
      $display("FAIL stall_writes: got %0d writes, %0d left expected %0d, 0", we_cnt - w0,
               exp_addr_q.size(), TOTAL);
    end
    tests++;
    if (cd - cl != 2) begin
      fails++;
      $display("FAIL stall_done_latency: got %0d expected 2", cd - cl);
    end
  endtask

  task automatic test_start_busy();
    int cs, cl, cd, ci, w0;
    w0 = we_cnt;
    run_load(4'd3, 1'b0, 10, cs, cl, cd, ci);
    tests++;
    if (we_cnt - w0 != TOTAL || exp_addr_q.size() != 0 || ci - cs != NBEATS + 3) begin
      fails++;
      $display("FAIL start_busy: got %0d writes, %0d left, %0d cycles expected %0d, 0, %0d",
               we_cnt - w0, exp_addr_q.size(), ci - cs, TOTAL, NBEATS + 3);
    end
  endtask

  task automatic test_reset_mid();
    int beat, w0, cs, cl, cd, ci;
    beat = 0;
    tick();
    start = 1'b1;
    base_addr = 4'd0;
    tick();
    start = 1'b0;
    for (int bound = 0; bound < 100 && beat < 3 * BEATS + 2; bound++) begin
      in_valid = 1'b1;
      in_data = beat_data(beat);
      if (in_ready) begin
        if (beat % BEATS == BEATS - 1) begin
          exp_addr_q.push_back(AW'(beat / BEATS));
          exp_data_q.push_back(row_model(beat / BEATS));
        end
        beat++;
      end
      tick();
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, in_ready, buf_we} !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_ctrl: busy/done/in_ready/we got %b expected 0000",
               {busy, done, in_ready, buf_we});
    end
    tests++;
    if (buf_addr_write !== '0 || buf_data_in !== '0) begin
      fails++;
      $display("FAIL midreset_bus: addr %0h data nonzero=%0b expected 0", buf_addr_write,
               |buf_data_in);
    end
    tests++;
    if (exp_addr_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_rows: got %0d rows unwritten expected 0", exp_addr_q.size());
    end
    w0 = we_cnt;
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    tests++;
    if (we_cnt != w0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_quiet: got %0d writes busy %b expected 0 writes busy 0",
               we_cnt - w0, busy);
    end
    in_valid = 1'b0;
    w0 = we_cnt;
    run_load(4'd0, 1'b0, -1, cs, cl, cd, ci);
    tests++;
    if (we_cnt - w0 != TOTAL || exp_addr_q.size() != 0 || ci - cs != NBEATS + 3) begin
      fails++;
      $display("FAIL midreset_reload: got %0d writes, %0d cycles expected %0d, %0d",
               we_cnt - w0, ci - cs, TOTAL, NBEATS + 3);
    end
  endtask

  task automatic test_idle_input();
    int cs, cl, cd, ci, w0;
    in_valid = 1'b1;
    in_data = '1;
    repeat (10) tick();
    tests++;
    if ({busy, in_ready, buf_we} !== 3'b000) begin
      fails++;
      $display("FAIL idle_quiet: busy/in_ready/we got %b expected 000", {busy, in_ready, buf_we});
    end
    w0 = we_cnt;
    run_load(4'd0, 1'b0, -1, cs, cl, cd, ci);
    tests++;
    if (we_cnt - w0 != TOTAL || exp_addr_q.size() != 0) begin
      fails++;
      $display("FAIL idle_writes: got %0d writes, %0d left expected %0d, 0", we_cnt - w0,
               exp_addr_q.size(), TOTAL);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stalls();
    test_start_busy();
    test_reset_mid();
    test_idle_input();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
